// File: rtl/dffs_mp_valid.sv
// Multi-port register array with per-entry valid tracking.
// NWR lane-masked write ports (highest port wins per lane), a masked bulk
// invalidate, and NRD read ports that either hold a registered pointer
// (MODE 0) or registered data with write-through forwarding (MODE 1).
module dffs_mp_valid #(
  parameter int SIZE = 3,
  parameter int WLEN = 32,
  parameter int STEP = 2,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int MODE = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NRD-1:0]            CENR,
  input  logic [NRD*SIZE-1:0]       AR,
  output logic [NRD*WLEN-1:0]       QR,
  output logic [NRD-1:0]            VR,
  input  logic [NWR-1:0]            CENW,
  input  logic [NWR*(2**STEP)-1:0]  WENW,
  input  logic [NWR*SIZE-1:0]       AW,
  input  logic [NWR*WLEN-1:0]       DW,
  input  logic                      CENI,
  input  logic [(2**SIZE)-1:0]      MASKI,
  output logic [(2**SIZE)-1:0]      VALID,
  output logic [SIZE:0]             NVALID,
  output logic                      FULL
);

  localparam int DEPTH = 2**SIZE;
  localparam int NLANE = 2**STEP;
  localparam int LW    = WLEN >> STEP;

  logic [WLEN-1:0]  mem     [DEPTH];
  logic [WLEN-1:0]  mem_nxt [DEPTH];
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic [SIZE:0]    pop_cnt;

  // Post-write image of the array; ports applied in ascending order so the
  // highest-index port wins each lane on a collision.
  always_comb begin
    mem_nxt = mem;
    wr_hit  = '0;
    for (int w = 0; w < NWR; w++) begin
      if (!CENW[w]) begin
        for (int j = 0; j < NLANE; j++) begin
          if (!WENW[w*NLANE + j]) begin
            mem_nxt[AW[w*SIZE +: SIZE]][j*LW +: LW] = DW[w*WLEN + j*LW +: LW];
            wr_hit[AW[w*SIZE +: SIZE]] = 1'b1;
          end
        end
      end
    end
  end

  // Invalidate first, then any write re-validates its entry.
  always_comb begin
    valid_nxt = valid;
    if (!CENI) valid_nxt = valid_nxt & ~MASKI;
    valid_nxt = valid_nxt | wr_hit;
  end

  // Array storage is not reset; writes are blocked while reset is asserted.
  always_ff @(posedge CLK) begin
    if (RST) mem <= mem_nxt;
  end

  // Valid vector register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) valid <= '0;
    else      valid <= valid_nxt;
  end

  // Population count of the valid vector.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < DEPTH; i++) pop_cnt = pop_cnt + (SIZE+1)'(valid[i]);
  end

  assign VALID  = valid;
  assign NVALID = pop_cnt;
  assign FULL   = &valid;

  generate
    if (MODE == 0) begin : g_ptr
      logic [SIZE-1:0] ptr [NRD];

      // Capture read pointers; data is looked up live so later writes show.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int r = 0; r < NRD; r++) ptr[r] <= '0;
        end else begin
          for (int r = 0; r < NRD; r++)
            if (!CENR[r]) ptr[r] <= AR[r*SIZE +: SIZE];
        end
      end

      // Combinational read through the stored pointers.
      always_comb begin
        QR = '0;
        VR = '0;
        for (int r = 0; r < NRD; r++) begin
          QR[r*WLEN +: WLEN] = mem[ptr[r]];
          VR[r]              = valid[ptr[r]];
        end
      end
    end else begin : g_data
      logic [WLEN-1:0] q_reg [NRD];
      logic [NRD-1:0]  v_reg;

      // Register the post-write entry so a same-cycle write is forwarded.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int r = 0; r < NRD; r++) q_reg[r] <= '0;
          v_reg <= '0;
        end else begin
          for (int r = 0; r < NRD; r++) begin
            if (!CENR[r]) begin
              q_reg[r] <= mem_nxt[AR[r*SIZE +: SIZE]];
              v_reg[r] <= valid_nxt[AR[r*SIZE +: SIZE]];
            end
          end
        end
      end

      // Drive packed read outputs from the holding registers.
      always_comb begin
        QR = '0;
        for (int r = 0; r < NRD; r++) QR[r*WLEN +: WLEN] = q_reg[r];
        VR = v_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dffs_mp_valid.sv
// Bench for dffs_mp_valid: one MODE 0 and one MODE 1 instance share stimulus
// and are compared against an entry/lane level model of the array.
module tb_dffs_mp_valid;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  CENR;
  logic [5:0]  AR;
  logic [1:0]  CENW;
  logic [7:0]  WENW;
  logic [5:0]  AW;
  logic [63:0] DW;
  logic        CENI;
  logic [7:0]  MASKI;

  logic [63:0] qr0, qr1;
  logic [1:0]  vr0, vr1;
  logic [7:0]  valid0, valid1;
  logic [3:0]  nvalid0, nvalid1;
  logic        full0, full1;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] mem_m [8];
  logic [7:0]  valid_m;
  logic [2:0]  ptr_m [2];
  logic [31:0] q1_m  [2];
  logic [1:0]  v1_m;

  always #5 CLK = ~CLK;

  dffs_mp_valid #(.SIZE(3), .WLEN(32), .STEP(2), .NRD(2), .NWR(2), .MODE(0)) dut0 (
    .CLK(CLK), .RST(RST), .CENR(CENR), .AR(AR), .QR(qr0), .VR(vr0),
    .CENW(CENW), .WENW(WENW), .AW(AW), .DW(DW), .CENI(CENI), .MASKI(MASKI),
    .VALID(valid0), .NVALID(nvalid0), .FULL(full0));

  dffs_mp_valid #(.SIZE(3), .WLEN(32), .STEP(2), .NRD(2), .NWR(2), .MODE(1)) dut1 (
    .CLK(CLK), .RST(RST), .CENR(CENR), .AR(AR), .QR(qr1), .VR(vr1),
    .CENW(CENW), .WENW(WENW), .AW(AW), .DW(DW), .CENI(CENI), .MASKI(MASKI),
    .VALID(valid1), .NVALID(nvalid1), .FULL(full1));

  task automatic idle();
    CENR = 2'b11; AR = '0; CENW = 2'b11; WENW = 8'hFF; AW = '0; DW = '0;
    CENI = 1'b1; MASKI = '0;
  endtask

  task automatic set_wr(input int w, input logic [2:0] a, input logic [3:0] wen, input logic [31:0] d);
    CENW[w] = 1'b0; WENW[w*4 +: 4] = wen; AW[w*3 +: 3] = a; DW[w*32 +: 32] = d;
  endtask

  task automatic set_rd(input int r, input logic [2:0] a);
    CENR[r] = 1'b0; AR[r*3 +: 3] = a;
  endtask

  // Advance one clock edge, update the model from the applied inputs, and
  // return at the following falling edge where outputs are sampled.
  task automatic tick();
    logic [31:0] nm [8];
    logic [7:0]  wrote;
    logic [7:0]  nv;
    logic [2:0]  a;
    @(posedge CLK);
    if (!RST) begin
      valid_m = '0; ptr_m[0] = '0; ptr_m[1] = '0;
      q1_m[0] = '0; q1_m[1] = '0; v1_m = '0;
    end else begin
      nm = mem_m; wrote = '0;
      for (int w = 0; w < 2; w++)
        if (!CENW[w])
          for (int j = 0; j < 4; j++)
            if (!WENW[w*4+j]) begin
              a = AW[w*3 +: 3];
              nm[a][j*8 +: 8] = DW[w*32 + j*8 +: 8];
              wrote[a] = 1'b1;
            end
      nv = valid_m;
      for (int i = 0; i < 8; i++) begin
        if (!CENI && MASKI[i]) nv[i] = 1'b0;
        if (wrote[i]) nv[i] = 1'b1;
      end
      for (int r = 0; r < 2; r++)
        if (!CENR[r]) begin
          a = AR[r*3 +: 3];
          ptr_m[r] = a;
          q1_m[r]  = nm[a];
          v1_m[r]  = nv[a];
        end
      mem_m = nm; valid_m = nv;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b0;
    #1;
    checks++; if (valid0 !== 8'h00 || valid1 !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h/%h exp 00", valid0, valid1); end
    checks++; if (nvalid0 !== 4'd0 || full0 !== 1'b0) begin errors++; $display("FAIL reset_nvalid_full: got %0d/%b exp 0/0", nvalid0, full0); end
    checks++; if (qr1 !== 64'h0 || vr1 !== 2'b00 || vr0 !== 2'b00) begin errors++; $display("FAIL reset_read: got qr1=%h vr1=%b vr0=%b exp 0", qr1, vr1, vr0); end
    tick();
    RST = 1'b1;
    tick();
    set_rd(0, 3'd5);
    tick();
    idle();
    checks++; if (vr0[0] !== 1'b0 || vr1[0] !== 1'b0) begin errors++; $display("FAIL read5_vr: got %b/%b exp 0", vr0[0], vr1[0]); end
    checks++; if (valid0 !== 8'h00 || nvalid0 !== 4'd0 || full0 !== 1'b0) begin errors++; $display("FAIL read5_state: got %h %0d %b exp 00 0 0", valid0, nvalid0, full0); end
  endtask

  task automatic test_write_read();
    set_wr(0, 3'd3, 4'b0000, 32'h11223344);
    tick(); idle();
    set_rd(1, 3'd3);
    tick(); idle();
    checks++; if (qr0[63:32] !== 32'h11223344 || qr1[63:32] !== 32'h11223344) begin errors++; $display("FAIL wr_full_qr: got %h/%h exp 11223344", qr0[63:32], qr1[63:32]); end
    checks++; if (vr0[1] !== 1'b1 || vr1[1] !== 1'b1 || valid0 !== 8'h08) begin errors++; $display("FAIL wr_full_valid: got vr %b/%b valid %h exp 1 1 08", vr0[1], vr1[1], valid0); end
    set_wr(0, 3'd3, 4'b1110, 32'hAABBCCDD);
    tick(); idle();
    set_rd(1, 3'd3);
    tick(); idle();
    checks++; if (qr0[63:32] !== 32'h112233DD || qr1[63:32] !== 32'h112233DD) begin errors++; $display("FAIL wr_lane0: got %h/%h exp 112233DD", qr0[63:32], qr1[63:32]); end
  endtask

  task automatic test_collision();
    set_wr(0, 3'd2, 4'b0000, 32'h1);
    set_wr(1, 3'd2, 4'b0000, 32'h2);
    tick(); idle();
    set_rd(0, 3'd2);
    tick(); idle();
    checks++; if (qr0[31:0] !== 32'h2 || qr1[31:0] !== 32'h2) begin errors++; $display("FAIL collide_win: got %h/%h exp 00000002", qr0[31:0], qr1[31:0]); end
    set_wr(0, 3'd2, 4'b1110, 32'h000000AA);
    set_wr(1, 3'd2, 4'b1101, 32'h0000BB00);
    tick(); idle();
    set_rd(0, 3'd2);
    tick(); idle();
    checks++; if (qr0[31:0] !== 32'h0000BBAA || qr1[31:0] !== 32'h0000BBAA) begin errors++; $display("FAIL collide_split: got %h/%h exp 0000BBAA", qr0[31:0], qr1[31:0]); end
  endtask

  task automatic test_invalidate();
    CENI = 1'b0; MASKI = 8'h08;
    set_wr(1, 3'd3, 4'b0000, 32'h55667788);
    tick(); idle();
    checks++; if (valid0[3] !== 1'b1 || valid1[3] !== 1'b1) begin errors++; $display("FAIL inval_write_wins: got %b/%b exp 1", valid0[3], valid1[3]); end
    CENI = 1'b0; MASKI = 8'hFF;
    tick(); idle();
    checks++; if (valid0 !== 8'h00 || nvalid0 !== 4'd0 || nvalid1 !== 4'd0) begin errors++; $display("FAIL inval_all: got %h %0d/%0d exp 00 0", valid0, nvalid0, nvalid1); end
    set_rd(0, 3'd3);
    tick(); idle();
    checks++; if (qr0[31:0] !== 32'h55667788 || qr1[31:0] !== 32'h55667788) begin errors++; $display("FAIL inval_retain: got %h/%h exp 55667788", qr0[31:0], qr1[31:0]); end
    checks++; if (vr0[0] !== 1'b0 || vr1[0] !== 1'b0) begin errors++; $display("FAIL inval_vr: got %b/%b exp 0", vr0[0], vr1[0]); end
  endtask

  task automatic test_forward();
    set_rd(0, 3'd4);
    set_wr(0, 3'd4, 4'b0000, 32'hCAFEF00D);
    tick(); idle();
    checks++; if (qr1[31:0] !== 32'hCAFEF00D || vr1[0] !== 1'b1) begin errors++; $display("FAIL fwd_m1: got %h vr %b exp CAFEF00D 1", qr1[31:0], vr1[0]); end
    set_wr(1, 3'd4, 4'b0000, 32'hDEADBEEF);
    tick(); idle();
    checks++; if (qr1[31:0] !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_m1: got %h exp CAFEF00D", qr1[31:0]); end
    set_rd(0, 3'd4);
    tick(); idle();
    tick();
    set_wr(0, 3'd4, 4'b0000, 32'h12345678);
    tick(); idle();
    checks++; if (qr0[31:0] !== 32'h12345678 || vr0[0] !== 1'b1) begin errors++; $display("FAIL live_m0: got %h vr %b exp 12345678 1", qr0[31:0], vr0[0]); end
    checks++; if (qr1[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stale_m1: got %h exp DEADBEEF", qr1[31:0]); end
  endtask

  task automatic test_full_reset();
    for (int k = 0; k < 4; k++) begin
      set_wr(0, 3'(2*k),   4'b0000, $urandom);
      set_wr(1, 3'(2*k+1), 4'b0000, $urandom);
      tick(); idle();
    end
    checks++; if (full0 !== 1'b1 || full1 !== 1'b1 || nvalid0 !== 4'd8 || valid0 !== 8'hFF) begin errors++; $display("FAIL full: got full %b/%b nvalid %0d valid %h exp 1 1 8 FF", full0, full1, nvalid0, valid0); end
    set_wr(0, 3'd1, 4'b0000, 32'h0BAD0BAD);
    set_wr(1, 3'd6, 4'b0000, 32'h0BADF00D);
    #2 RST = 1'b0;
    #1;
    checks++; if (valid0 !== 8'h00 || valid1 !== 8'h00 || full0 !== 1'b0 || full1 !== 1'b0) begin errors++; $display("FAIL async_reset: got %h/%h full %b/%b exp 00 0", valid0, valid1, full0, full1); end
    tick();
    idle();
    RST = 1'b1;
    checks++; if (valid0 !== 8'h00 || qr1 !== 64'h0 || vr1 !== 2'b00) begin errors++; $display("FAIL reset_discard: got valid %h qr1 %h vr1 %b exp 0", valid0, qr1, vr1); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      idle();
      for (int w = 0; w < 2; w++)
        if ($urandom_range(0, 2) != 0) set_wr(w, 3'($urandom_range(0, 7)), 4'($urandom), $urandom);
      if ($urandom_range(0, 1) == 0) AW[5:3] = AW[2:0];
      if ($urandom_range(0, 5) == 0) begin CENI = 1'b0; MASKI = 8'($urandom); end
      for (int r = 0; r < 2; r++)
        if ($urandom_range(0, 1) == 0) set_rd(r, 3'($urandom_range(0, 7)));
      tick();
      checks++; if (valid0 !== valid_m || valid1 !== valid_m) begin errors++; $display("FAIL rnd_valid: got %h/%h exp %h", valid0, valid1, valid_m); end
      checks++; if (nvalid0 !== 4'($countones(valid_m)) || full0 !== (&valid_m) || full1 !== (&valid_m)) begin errors++; $display("FAIL rnd_count: got %0d full %b exp %0d %b", nvalid0, full0, $countones(valid_m), &valid_m); end
      for (int r = 0; r < 2; r++) begin
        checks++; if (qr0[r*32 +: 32] !== mem_m[ptr_m[r]] || vr0[r] !== valid_m[ptr_m[r]]) begin errors++; $display("FAIL rnd_m0 port %0d: got %h/%b exp %h/%b", r, qr0[r*32 +: 32], vr0[r], mem_m[ptr_m[r]], valid_m[ptr_m[r]]); end
        checks++; if (qr1[r*32 +: 32] !== q1_m[r] || vr1[r] !== v1_m[r]) begin errors++; $display("FAIL rnd_m1 port %0d: got %h/%b exp %h/%b", r, qr1[r*32 +: 32], vr1[r], q1_m[r], v1_m[r]); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    RST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_write_read();
    test_collision();
    test_invalidate();
    test_forward();
    test_full_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dffs_mp_valid.md
DFFS_MP_VALID -- requirements
Module: dffs_mp_valid

Interface
REQ-001 SIZE, 3, address width; the array holds 2**SIZE entries.
REQ-002 WLEN, 32, word width in bits.
REQ-003 STEP, 2, log2 of the number of write lanes per word; lane width W = WLEN>>STEP; WLEN SHALL be divisible by 2**STEP.
REQ-004 NRD, 2, number of read ports.
REQ-005 NWR, 2, number of write ports.
REQ-006 MODE, 0, read style: 0 = registered pointer, 1 = registered data with write-through.
REQ-007 CLK  input  1  clock; all state updates on the rising edge.
REQ-008 RST  input  1  reset, asynchronous, active-low.
REQ-009 CENR  input  NRD  per-read-port enable, active-low.
REQ-010 AR  input  NRD*SIZE  packed read addresses; port r uses bits [r*SIZE+:SIZE].
REQ-011 QR  output  NRD*WLEN  packed read data.
REQ-012 VR  output  NRD  valid flag of each read port's entry.
REQ-013 CENW  input  NWR  per-write-port enable, active-low.
REQ-014 WENW  input  NWR*2**STEP  per-port lane write enables, active-low.
REQ-015 AW  input  NWR*SIZE  packed write addresses.
REQ-016 DW  input  NWR*WLEN  packed write data.
REQ-017 CENI  input  1  invalidate enable, active-low.
REQ-018 MASKI  input  2**SIZE  entries to invalidate, active-high.
REQ-019 VALID  output  2**SIZE  per-entry valid vector.
REQ-020 NVALID  output  SIZE+1  population count of VALID.
REQ-021 FULL  output  1  high when every VALID bit is 1.

Function
REQ-022 Write: when CENW[w]=0 and WENW lane j of port w is 0, the block SHALL write lane j of DW[w] into lane j of MEM[AW[w]] at the edge; other lanes SHALL be unchanged.
REQ-023 Write collision: when two or more ports write the same lane of the same entry in one cycle, the highest-index port SHALL win, resolved per lane.
REQ-024 Valid set: any lane write to entry i SHALL set VALID[i]=1 at the same edge.
REQ-025 Invalidate: when CENI=0, every entry i with MASKI[i]=1 SHALL have VALID[i] cleared at the edge; MEM contents SHALL be retained.
REQ-026 Simultaneous invalidate and write to the same entry: the write SHALL win, leaving VALID[i]=1.
REQ-027 MODE 0: when CENR[r]=0, pointer P_r SHALL capture AR[r] at the edge; QR[r]=MEM[P_r] and VR[r]=VALID[P_r] combinationally, so later writes to P_r SHALL be visible without a new read.
REQ-028 MODE 1: when CENR[r]=0, QR[r] and VR[r] SHALL be registered at the edge from the post-write value of the entry, so a same-cycle write is forwarded; both SHALL hold while CENR[r]=1.
REQ-029 Read latency SHALL be one cycle in both modes.
REQ-030 Read ports SHALL be independent; reading the same address on several ports SHALL be legal.
REQ-031 NVALID and FULL SHALL be combinational from VALID.

Reset
REQ-032 RST=0 SHALL immediately clear VALID, all P_r, and (in MODE 1) QR and VR to 0.
REQ-033 MEM SHALL NOT be reset; QR in MODE 0 after reset is MEM[0] and is don't-care while VR=0.
REQ-034 Writes and invalidates pending in the reset cycle SHALL be discarded.

Verification
Configuration for all scenarios: SIZE=3, WLEN=32, STEP=2, NRD=2, NWR=2.
REQ-035 Reset, then read address 5 on port 0 -> VR[0]=0, VALID=0x00, NVALID=0, FULL=0.
REQ-036 Port 0 writes address 3 with D=0x11223344 and WENW=0000; port 1 reads address 3 next cycle -> QR=0x11223344, VR=1, VALID=0x08. Then a lane-0-only write (WENW=1110, D=0xAABBCCDD) -> read gives 0x112233DD.
REQ-037 Ports 0 and 1 both fully write address 2, with 0x1 and 0x2 respectively -> MEM[2]=0x2. Then lane split: port 0 writes lane 0 only and port 1 writes lane 1 only -> both lanes are updated.
REQ-038 CENI=0 with MASKI=0x08 while port 1 writes address 3 -> VALID[3]=1. Then MASKI=0xFF with no write -> VALID=0, NVALID=0, and a read of address 3 returns the retained data with VR=0.
REQ-039 MODE 1: read and write address 4 (0xCAFEF00D) in the same cycle -> QR=0xCAFEF00D next cycle, and QR holds after CENR goes high. MODE 0: write address 4 two cycles after the read capture -> QR follows the new data.
REQ-040 Write all 8 entries -> FULL=1, NVALID=8. Then assert RST low mid-cycle with writes pending -> VALID=0 without waiting for a clock edge, FULL=0.
